// File: rtl/redmule_tile_sequencer.sv
// redmule_tile_sequencer
// Walks the RedMulE tile loop nest (X rows outermost, then W columns, then
// X columns innermost) and issues one tile command per step over a
// valid/ready handshake, with leftover-aware tile extents and
// first/last-accumulation flags.
// Optional feature macro: REDMULE_SEQ_STORE_CNT_EN adds store_cnt_o, a count
// of accepted tiles that carry tile_last_o.

module redmule_tile_sequencer #(
   parameter int unsigned ARRAY_WIDTH  = 12,
   parameter int unsigned ARRAY_HEIGHT = 4,
   parameter int unsigned PIPE_REGS    = 3,
   parameter int unsigned IW           = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          start_i,
   input  logic [IW-1:0] x_rows_iter_i,
   input  logic [IW-1:0] w_cols_iter_i,
   input  logic [IW-1:0] x_cols_iter_i,
   input  logic [7:0]    x_rows_lftovr_i,
   input  logic [7:0]    w_cols_lftovr_i,
   input  logic [7:0]    x_cols_lftovr_i,
   output logic          tile_valid_o,
   input  logic          tile_ready_i,
   output logic [IW-1:0] tile_row_o,
   output logic [IW-1:0] tile_wcol_o,
   output logic [IW-1:0] tile_xcol_o,
   output logic [7:0]    tile_rows_o,
   output logic [7:0]    tile_wcols_o,
   output logic [7:0]    tile_xcols_o,
   output logic          tile_first_o,
   output logic          tile_last_o,
   output logic          busy_o,
   output logic          done_o
`ifdef REDMULE_SEQ_STORE_CNT_EN
   ,
   output logic [31:0]   store_cnt_o
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] FULL_ROWS = 8'(ARRAY_WIDTH);
   localparam logic [7:0] FULL_COLS = 8'(ARRAY_HEIGHT * (PIPE_REGS + 1));

   logic [1:0]    r_state;
   logic [IW-1:0] r_xRowsIter;
   logic [IW-1:0] r_wColsIter;
   logic [IW-1:0] r_xColsIter;
   logic [7:0]    r_xRowsLftovr;
   logic [7:0]    r_wColsLftovr;
   logic [7:0]    r_xColsLftovr;
   logic [IW-1:0] r_row;
   logic [IW-1:0] r_wcol;
   logic [IW-1:0] r_xcol;

   logic w_run;
   logic w_handshake;
   logic w_rowLast;
   logic w_wcolLast;
   logic w_xcolLast;
   logic w_anyZero;

   assign w_run       = (r_state == RUN);
   assign w_handshake = w_run & tile_ready_i;
   assign w_rowLast   = (r_row  == r_xRowsIter - IW'(1));
   assign w_wcolLast  = (r_wcol == r_wColsIter - IW'(1));
   assign w_xcolLast  = (r_xcol == r_xColsIter - IW'(1));
   assign w_anyZero   = (x_rows_iter_i == '0) | (w_cols_iter_i == '0) |
                        (x_cols_iter_i == '0);

   // Sequencer state, latched configuration and loop counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= IDLE;
         r_xRowsIter   <= '0;
         r_wColsIter   <= '0;
         r_xColsIter   <= '0;
         r_xRowsLftovr <= '0;
         r_wColsLftovr <= '0;
         r_xColsLftovr <= '0;
         r_row         <= '0;
         r_wcol        <= '0;
         r_xcol        <= '0;
      end else if (clear_i) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_wcol  <= '0;
         r_xcol  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_xRowsIter   <= x_rows_iter_i;
                  r_wColsIter   <= w_cols_iter_i;
                  r_xColsIter   <= x_cols_iter_i;
                  r_xRowsLftovr <= x_rows_lftovr_i;
                  r_wColsLftovr <= w_cols_lftovr_i;
                  r_xColsLftovr <= x_cols_lftovr_i;
                  r_row         <= '0;
                  r_wcol        <= '0;
                  r_xcol        <= '0;
                  r_state       <= w_anyZero ? DONE : RUN;
               end
            end
            RUN: begin
               if (tile_ready_i) begin
                  if (!w_xcolLast) begin
                     r_xcol <= r_xcol + IW'(1);
                  end else begin
                     r_xcol <= '0;
                     if (!w_wcolLast) begin
                        r_wcol <= r_wcol + IW'(1);
                     end else begin
                        r_wcol <= '0;
                        if (!w_rowLast) begin
                           r_row <= r_row + IW'(1);
                        end else begin
                           r_row   <= '0;
                           r_state <= DONE;
                        end
                     end
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tile_valid_o = w_run;
   assign busy_o       = (r_state != IDLE);
   assign done_o       = (r_state == DONE);
   assign tile_row_o   = r_row;
   assign tile_wcol_o  = r_wcol;
   assign tile_xcol_o  = r_xcol;
   assign tile_first_o = w_run & (r_xcol == '0);
   assign tile_last_o  = w_run & w_xcolLast;

   // Extents fall back to a leftover size only on the last index of a loop
   // that has one; outside RUN they read zero
   always_comb begin
      tile_rows_o  = 8'd0;
      tile_wcols_o = 8'd0;
      tile_xcols_o = 8'd0;
      if (w_run) begin
         tile_rows_o  = (w_rowLast  && r_xRowsLftovr != 8'd0) ? r_xRowsLftovr : FULL_ROWS;
         tile_wcols_o = (w_wcolLast && r_wColsLftovr != 8'd0) ? r_wColsLftovr : FULL_COLS;
         tile_xcols_o = (w_xcolLast && r_xColsLftovr != 8'd0) ? r_xColsLftovr : FULL_COLS;
      end
   end

`ifdef REDMULE_SEQ_STORE_CNT_EN
   logic [31:0] r_storeCnt;

   // Counts accepted tiles that close an accumulation (i.e. trigger a store)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_storeCnt <= '0;
      end else if (clear_i) begin
         r_storeCnt <= '0;
      end else if (r_state == IDLE && start_i) begin
         r_storeCnt <= '0;
      end else if (w_handshake && w_xcolLast) begin
         r_storeCnt <= r_storeCnt + 32'd1;
      end
   end

   assign store_cnt_o = r_storeCnt;
`endif

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// tb_redmule_tile_sequencer
// Directed bench for redmule_tile_sequencer. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// Optional feature macro: REDMULE_SEQ_STORE_CNT_EN (store_cnt_o checks).

module tb_redmule_tile_sequencer;

   localparam int IW = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i;
   logic          start_i;
   logic [IW-1:0] x_rows_iter_i;
   logic [IW-1:0] w_cols_iter_i;
   logic [IW-1:0] x_cols_iter_i;
   logic [7:0]    x_rows_lftovr_i;
   logic [7:0]    w_cols_lftovr_i;
   logic [7:0]    x_cols_lftovr_i;
   logic          tile_valid_o;
   logic          tile_ready_i;
   logic [IW-1:0] tile_row_o;
   logic [IW-1:0] tile_wcol_o;
   logic [IW-1:0] tile_xcol_o;
   logic [7:0]    tile_rows_o;
   logic [7:0]    tile_wcols_o;
   logic [7:0]    tile_xcols_o;
   logic          tile_first_o;
   logic          tile_last_o;
   logic          busy_o;
   logic          done_o;
`ifdef REDMULE_SEQ_STORE_CNT_EN
   logic [31:0]   store_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   redmule_tile_sequencer #(
      .ARRAY_WIDTH(12), .ARRAY_HEIGHT(4), .PIPE_REGS(3), .IW(IW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .x_rows_iter_i(x_rows_iter_i), .w_cols_iter_i(w_cols_iter_i),
      .x_cols_iter_i(x_cols_iter_i), .x_rows_lftovr_i(x_rows_lftovr_i),
      .w_cols_lftovr_i(w_cols_lftovr_i), .x_cols_lftovr_i(x_cols_lftovr_i),
      .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
      .tile_row_o(tile_row_o), .tile_wcol_o(tile_wcol_o), .tile_xcol_o(tile_xcol_o),
      .tile_rows_o(tile_rows_o), .tile_wcols_o(tile_wcols_o), .tile_xcols_o(tile_xcols_o),
      .tile_first_o(tile_first_o), .tile_last_o(tile_last_o),
      .busy_o(busy_o), .done_o(done_o)
`ifdef REDMULE_SEQ_STORE_CNT_EN
      , .store_cnt_o(store_cnt_o)
`endif
   );

   // Free-running clock, period 10
   always #5 clk_i = ~clk_i;

   // Advance one clock and settle just past the rising edge
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Pulse start_i for one edge with the given configuration
   task automatic applyStimulus(input int xr, input int wc, input int xc,
                                input int lr, input int lw, input int lx);
      start_i         = 1'b1;
      x_rows_iter_i   = IW'(xr);
      w_cols_iter_i   = IW'(wc);
      x_cols_iter_i   = IW'(xc);
      x_rows_lftovr_i = 8'(lr);
      w_cols_lftovr_i = 8'(lw);
      x_cols_lftovr_i = 8'(lx);
      cycle();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #23;
      total++; if (tile_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", tile_valid_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
      total++; if ({tile_first_o, tile_last_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {tile_first_o, tile_last_o}); end
      total++; if ({tile_row_o, tile_wcol_o, tile_xcol_o} !== 48'd0) begin bad++; $display("FAIL reset_idx got=%h want=0", {tile_row_o, tile_wcol_o, tile_xcol_o}); end
      total++; if ({tile_rows_o, tile_wcols_o, tile_xcols_o} !== 24'd0) begin bad++; $display("FAIL reset_ext got=%h want=0", {tile_rows_o, tile_wcols_o, tile_xcols_o}); end
`ifdef REDMULE_SEQ_STORE_CNT_EN
      total++; if (store_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_store_cnt got=%0d want=0", store_cnt_o); end
`endif
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle();
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy_o); end
   endtask

   task automatic test_basic();
      tile_ready_i = 1'b1;
      applyStimulus(2, 2, 2, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         total++; if (tile_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid[%0d] got=%b want=1", i, tile_valid_o); end
         total++; if (tile_row_o !== IW'(i / 4) || tile_wcol_o !== IW'((i / 2) % 2) || tile_xcol_o !== IW'(i % 2)) begin
            bad++; $display("FAIL basic_idx[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", i, tile_row_o, tile_wcol_o, tile_xcol_o, i / 4, (i / 2) % 2, i % 2);
         end
         total++; if (tile_first_o !== (i % 2 == 0) || tile_last_o !== (i % 2 == 1)) begin
            bad++; $display("FAIL basic_flags[%0d] got=%b%b want=%b%b", i, tile_first_o, tile_last_o, i % 2 == 0, i % 2 == 1);
         end
         total++; if (tile_rows_o !== 8'd12 || tile_wcols_o !== 8'd16 || tile_xcols_o !== 8'd16) begin
            bad++; $display("FAIL basic_ext[%0d] got=%0d/%0d/%0d want=12/16/16", i, tile_rows_o, tile_wcols_o, tile_xcols_o);
         end
         total++; if (done_o !== 1'b0) begin bad++; $display("FAIL basic_early_done[%0d] got=%b want=0", i, done_o); end
         cycle();
      end
      total++; if (done_o !== 1'b1 || tile_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         bad++; $display("FAIL basic_done got=done%b valid%b busy%b want=done1 valid0 busy1", done_o, tile_valid_o, busy_o);
      end
`ifdef REDMULE_SEQ_STORE_CNT_EN
      total++; if (store_cnt_o !== 32'd4) begin bad++; $display("FAIL basic_store_cnt got=%0d want=4", store_cnt_o); end
`endif
      cycle();
      total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         bad++; $display("FAIL basic_idle got=done%b busy%b want=done0 busy0", done_o, busy_o);
      end
`ifdef REDMULE_SEQ_STORE_CNT_EN
      total++; if (store_cnt_o !== 32'd4) begin bad++; $display("FAIL basic_store_hold got=%0d want=4", store_cnt_o); end
`endif
   endtask

   task automatic test_zero_trip();
      tile_ready_i = 1'b1;
      applyStimulus(1, 3, 0, 0, 0, 0);
      total++; if (tile_valid_o !== 1'b0 || done_o !== 1'b1) begin
         bad++; $display("FAIL zero_trip_done got=valid%b done%b want=valid0 done1", tile_valid_o, done_o);
      end
      cycle();
      total++; if (tile_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
         bad++; $display("FAIL zero_trip_idle got=valid%b done%b busy%b want=000", tile_valid_o, done_o, busy_o);
      end
   endtask

   task automatic test_leftover();
      tile_ready_i = 1'b1;
      applyStimulus(2, 1, 1, 5, 7, 0);
      total++; if (tile_rows_o !== 8'd12 || tile_wcols_o !== 8'd7 || tile_xcols_o !== 8'd16) begin
         bad++; $display("FAIL lftovr_tile0 got=%0d/%0d/%0d want=12/7/16", tile_rows_o, tile_wcols_o, tile_xcols_o);
      end
      total++; if (tile_first_o !== 1'b1 || tile_last_o !== 1'b1) begin
         bad++; $display("FAIL lftovr_flags got=%b%b want=11", tile_first_o, tile_last_o);
      end
      cycle();
      total++; if (tile_row_o !== IW'(1) || tile_rows_o !== 8'd5 || tile_wcols_o !== 8'd7 || tile_xcols_o !== 8'd16) begin
         bad++; $display("FAIL lftovr_tile1 got=row%0d %0d/%0d/%0d want=row1 5/7/16", tile_row_o, tile_rows_o, tile_wcols_o, tile_xcols_o);
      end
      cycle();
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL lftovr_done got=%b want=1", done_o); end
      cycle();
   endtask

   task automatic test_backpressure();
      int k = 0;
      int stall = 3;
      tile_ready_i = 1'b1;
      applyStimulus(1, 1, 4, 0, 0, 0);
      for (int c = 0; c < 12 && k < 4; c++) begin
         total++; if (tile_valid_o !== 1'b1 || tile_xcol_o !== IW'(k)) begin
            bad++; $display("FAIL bp_payload[c%0d] got=valid%b xcol%0d want=valid1 xcol%0d", c, tile_valid_o, tile_xcol_o, k);
         end
         total++; if (tile_first_o !== (k == 0) || tile_last_o !== (k == 3) || done_o !== 1'b0) begin
            bad++; $display("FAIL bp_flags[c%0d] got=%b%b done%b want=%b%b done0", c, tile_first_o, tile_last_o, done_o, k == 0, k == 3);
         end
         if (k == 1 && stall > 0) begin
            tile_ready_i = 1'b0;
            stall--;
         end else begin
            tile_ready_i = 1'b1;
         end
         cycle();
         if (tile_ready_i) k++;
      end
      tile_ready_i = 1'b1;
      total++; if (k !== 4) begin bad++; $display("FAIL bp_timeout got=%0d want=4", k); end
      total++; if (done_o !== 1'b1 || tile_valid_o !== 1'b0) begin
         bad++; $display("FAIL bp_done got=done%b valid%b want=done1 valid0", done_o, tile_valid_o);
      end
      cycle();
   endtask

   task automatic test_clear();
      tile_ready_i = 1'b1;
      applyStimulus(2, 2, 2, 0, 0, 0);
      cycle();
      cycle();
      total++; if (tile_wcol_o !== IW'(1) || tile_xcol_o !== IW'(0)) begin
         bad++; $display("FAIL clear_pre got=%0d/%0d want=1/0", tile_wcol_o, tile_xcol_o);
      end
      clear_i = 1'b1;
      applyStimulus(1, 1, 1, 0, 0, 0);
      clear_i = 1'b0;
      total++; if (tile_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         bad++; $display("FAIL clear_state got=valid%b busy%b done%b want=000", tile_valid_o, busy_o, done_o);
      end
      total++; if ({tile_row_o, tile_wcol_o, tile_xcol_o} !== 48'd0) begin
         bad++; $display("FAIL clear_idx got=%h want=0", {tile_row_o, tile_wcol_o, tile_xcol_o});
      end
      for (int c = 0; c < 3; c++) begin
         cycle();
         total++; if (tile_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL clear_after[%0d] got=valid%b done%b busy%b want=000", c, tile_valid_o, done_o, busy_o);
         end
      end
   endtask

   task automatic test_restart_ignored();
      tile_ready_i = 1'b1;
      applyStimulus(1, 2, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         total++; if (tile_valid_o !== 1'b1 || tile_row_o !== IW'(0) || tile_wcol_o !== IW'(i / 2) || tile_xcol_o !== IW'(i % 2)) begin
            bad++; $display("FAIL restart_idx[%0d] got=valid%b %0d/%0d/%0d want=valid1 0/%0d/%0d", i, tile_valid_o, tile_row_o, tile_wcol_o, tile_xcol_o, i / 2, i % 2);
         end
         total++; if (tile_rows_o !== 8'd12 || tile_wcols_o !== 8'd16 || tile_xcols_o !== 8'd16) begin
            bad++; $display("FAIL restart_ext[%0d] got=%0d/%0d/%0d want=12/16/16", i, tile_rows_o, tile_wcols_o, tile_xcols_o);
         end
         if (i == 1) applyStimulus(2, 2, 2, 3, 3, 3);
         else        cycle();
      end
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL restart_done got=%b want=1", done_o); end
      cycle();
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL restart_idle got=%b want=0", busy_o); end
   endtask

   // Test sequence
   initial begin
      rst_ni          = 1'b0;
      clear_i         = 1'b0;
      start_i         = 1'b0;
      tile_ready_i    = 1'b0;
      x_rows_iter_i   = '0;
      w_cols_iter_i   = '0;
      x_cols_iter_i   = '0;
      x_rows_lftovr_i = '0;
      w_cols_lftovr_i = '0;
      x_cols_lftovr_i = '0;
      test_reset();
      test_basic();
      test_zero_trip();
      test_leftover();
      test_backpressure();
      test_clear();
      test_restart_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/redmule_tile_sequencer.md
# redmule_tile_sequencer

Walks the RedMulE tile loop nest (X rows, then W columns, then X columns) from the iteration counts and leftovers produced by the tiler, and issues one tile command per step to the engine/streamer control over a valid/ready handshake. It sits between the tiler output and the scheduler, owning loop order, leftover-tile sizing and first/last-accumulation marking. Completion is signalled to the top-level FSM.

## Interface
- ARRAY_WIDTH, 12, PE array rows; full X-row tile size
- ARRAY_HEIGHT, 4, PE array columns
- PIPE_REGS, 3, FMA pipeline depth; full column tile size is ARRAY_HEIGHT*(PIPE_REGS+1)
- IW, 16, iteration counter width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear, highest priority
- start_i  in  1  one-cycle pulse; config inputs valid this cycle
- x_rows_iter_i / w_cols_iter_i / x_cols_iter_i  in  IW  loop trip counts
- x_rows_lftovr_i / w_cols_lftovr_i / x_cols_lftovr_i  in  8  leftover sizes; 0 = none
- tile_valid_o  out  1  tile command valid
- tile_ready_i  in  1  consumer accepts tile
- tile_row_o / tile_wcol_o / tile_xcol_o  out  IW  current loop indices
- tile_rows_o / tile_wcols_o / tile_xcols_o  out  8  effective tile extents
- tile_first_o  out  1  tile_xcol_o == 0 (accumulator init)
- tile_last_o  out  1  tile_xcol_o == x_cols_iter-1 (store after tile)
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: on start_i, latch all config inputs and zero the counters. If any trip count == 0, go to DONE without issuing tiles; else go to RUN.
- RUN: tile_valid_o = 1. On valid&ready, advance the counters:
  - xcol increments; wraps to 0 at x_cols_iter-1 and increments wcol.
  - wcol wraps to 0 at w_cols_iter-1 and increments row.
  - Handshake at the final index (all three at max) -> DONE.
- DONE: done_o = 1 for exactly one cycle -> IDLE.
- start_i outside IDLE is ignored; the latched config is unaffected.
- Extent rules:
  - tile_rows_o = x_rows_lftovr if row is last and lftovr != 0, else ARRAY_WIDTH.
  - tile_wcols_o and tile_xcols_o follow the same rule with ARRAY_HEIGHT*(PIPE_REGS+1).
- Total tiles = x_rows*w_cols*x_cols. Total tile_last handshakes = x_rows*w_cols (tiler tot_stores).
- clear_i: next state IDLE, counters 0, done_o not asserted, in-flight tile dropped. Applies in any state and wins over simultaneous start_i or handshake.

## Timing
- Reset values: state IDLE; all counters 0; tile_valid_o, busy_o, done_o, tile_first_o, tile_last_o = 0; all index and extent outputs 0.
- All outputs are registered or decoded from registers only; no combinational path from tile_ready_i to any output.
- tile_valid_o rises the cycle after start_i.
- Throughput is one tile per cycle while tile_ready_i = 1.
- Payload is held stable while valid && !ready. Valid never drops before the handshake except on clear_i.
- done_o is asserted the cycle after the final handshake. With a zero trip count, done_o is asserted the cycle after start_i.
- busy_o goes low in the same cycle IDLE is re-entered; a new start_i is accepted in that cycle.

## Configuration
- REDMULE_SEQ_STORE_CNT_EN defined:
  - Adds port store_cnt_o, out, 32: count of handshakes with tile_last_o = 1.
  - Zeroed on start_i and on clear_i; holds its value after done_o.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Trip counts 2/2/2, no leftovers, ready held 1 -> 8 consecutive tiles in order (0,0,0),(0,0,1),(0,1,0)…(1,1,1); first/last alternate; done_o one cycle after the 8th; store_cnt_o = 4 with macro defined.
- Trip counts 1/3/0 -> no tile_valid_o; done_o the cycle after start_i.
- Trip counts 2/1/1 with x_rows_lftovr = 5, w_cols_lftovr = 7 -> tile_rows_o 12 then 5; tile_wcols_o = 7 on both tiles.
- Trip counts 1/1/4, tile_ready_i low for 3 cycles at tile 2 -> valid and payload stable; 4 tiles total; done_o after the last handshake.
- clear_i during tile 3 of 8, with start_i pulsed the same cycle -> tile_valid_o low next cycle; state IDLE; no done_o; start ignored.
- start_i pulsed mid-RUN with different config -> sequence completes using the original config.
